// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared types for the tick-strobed debouncer. The state
//                encoding is also visible to the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW        = 2'd0,
        S_MAYBE_HIGH = 2'd1,
        S_HIGH       = 2'd2,
        S_MAYBE_LOW  = 2'd3
    } state_t;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous bit,
//                asynchronous active-low reset to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    // Next values: shift the raw bit through two stages
    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
    end

    // Synchronizer stages, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q = sync2_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/tick_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tick_debouncer
//  Description : Debounces one asynchronous input, sampling only on the
//                one-cycle tick strobe. Produces a clean level, rise/fall
//                strobes and a wrapping press counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             bouncy_in,
    output logic             debounced,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] press_count
);

    localparam int                  c_cnt_w = $clog2(STABLE_TICKS + 1);
    localparam logic [c_cnt_w-1:0]  c_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0]    c_zero  = '0;

    logic                s_in;
    state_t              state_q, state_d;
    logic [c_cnt_w-1:0]  count_q, count_d;
    logic                debounced_q, debounced_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic [CNT_W-1:0]    press_count_q, press_count_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bouncy_in),
        .q   (s_in)
    );

    // Next-state logic: advance only on a tick, require STABLE_TICKS agreeing samples
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (tick) begin
            unique case (state_q)
                S_LOW: begin
                    if (s_in) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = S_HIGH;
                            count_d = '0;
                        end else begin
                            state_d = S_MAYBE_HIGH;
                            count_d = c_one;
                        end
                    end else begin
                        count_d = '0;
                    end
                end
                S_MAYBE_HIGH: begin
                    if (!s_in) begin
                        state_d = S_LOW;
                        count_d = '0;
                    end else if (count_q == c_last) begin
                        state_d = S_HIGH;
                        count_d = '0;
                    end else begin
                        count_d = count_q + c_one;
                    end
                end
                S_HIGH: begin
                    if (!s_in) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = S_LOW;
                            count_d = '0;
                        end else begin
                            state_d = S_MAYBE_LOW;
                            count_d = c_one;
                        end
                    end else begin
                        count_d = '0;
                    end
                end
                S_MAYBE_LOW: begin
                    if (s_in) begin
                        state_d = S_HIGH;
                        count_d = '0;
                    end else if (count_q == c_last) begin
                        state_d = S_LOW;
                        count_d = '0;
                    end else begin
                        count_d = count_q + c_one;
                    end
                end
                default: begin
                    state_d = S_LOW;
                    count_d = '0;
                end
            endcase
        end
    end

    // Output next values: level follows the registered state one cycle later,
    // strobes mark the first cycle of a new level
    always_comb begin
        debounced_d   = (state_q == S_HIGH) || (state_q == S_MAYBE_LOW);
        rise_d        = debounced_d & ~debounced_q;
        fall_d        = ~debounced_d & debounced_q;
        press_count_d = press_count_q + {c_zero[CNT_W-1:1], rise_d};
    end

    // State, counter and output registers; reset discards all progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_LOW;
            count_q       <= '0;
            debounced_q   <= 1'b0;
            rise_q        <= 1'b0;
            fall_q        <= 1'b0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            debounced_q   <= debounced_d;
            rise_q        <= rise_d;
            fall_q        <= fall_d;
            press_count_q <= press_count_d;
        end
    end

    assign debounced   = debounced_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    assign press_count = press_count_q;

endmodule : tick_debouncer
`default_nettype wire

// File: tb/tb_tick_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tick_debouncer
//  Description : Directed self-checking bench for tick_debouncer
//                (STABLE_TICKS=4 main instance, STABLE_TICKS=1 side instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_debouncer;
    import debounce_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       bouncy_in = 1'b0;
    logic       debounced, rise, fall;
    logic [7:0] press_count;

    logic       tick1 = 1'b0;
    logic       bouncy1 = 1'b0;
    logic       debounced1, rise1, fall1;
    logic [7:0] press_count1;

    int checks   = 0;
    int failures = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    tick_debouncer #(.STABLE_TICKS(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .bouncy_in   (bouncy_in),
        .debounced   (debounced),
        .rise        (rise),
        .fall        (fall),
        .press_count (press_count)
    );

    tick_debouncer #(.STABLE_TICKS(1), .CNT_W(8)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick1),
        .bouncy_in   (bouncy1),
        .debounced   (debounced1),
        .rise        (rise1),
        .fall        (fall1),
        .press_count (press_count1)
    );

    // Count strobe cycles of the main instance
    always @(posedge clk) begin
        if (rise) rise_cnt++;
        if (fall) fall_cnt++;
        if (rise && fall) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Nine idle cycles, then one cycle with tick high
    task automatic tick_period();
        repeat (9) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    initial begin
        int r0;
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        check("reset_debounced", debounced, 0);
        check("reset_press_count", press_count, 0);
        check("reset_state", dut.state_q, S_LOW);

        // Glitch: high for two ticks, then low
        r0 = rise_cnt;
        bouncy_in = 1'b1;
        tick_period();
        check("glitch_maybe_high", dut.state_q, S_MAYBE_HIGH);
        tick_period();
        check("glitch_count2", dut.count_q, 2);
        bouncy_in = 1'b0;
        tick_period();
        check("glitch_back_low", dut.state_q, S_LOW);
        step();
        check("glitch_debounced", debounced, 0);
        check("glitch_no_rise", rise_cnt - r0, 0);

        // Clean press, tick every 10 cycles
        bouncy_in = 1'b1;
        repeat (4) tick_period();
        check("press_state_high", dut.state_q, S_HIGH);
        check("press_deb_not_yet", debounced, 0);
        step();
        check("press_debounced", debounced, 1);
        check("press_rise", rise, 1);
        check("press_count1", press_count, 1);
        step();
        check("press_rise_one_cycle", rise, 0);
        check("press_single_rise", rise_cnt - r0, 1);

        // Clean release
        bouncy_in = 1'b0;
        repeat (3) tick_period();
        check("release_maybe_low", dut.state_q, S_MAYBE_LOW);
        check("release_still_high", debounced, 1);
        tick_period();
        step();
        check("release_debounced", debounced, 0);
        check("release_fall", fall, 1);
        check("release_count_same", press_count, 1);
        step();
        check("release_fall_one_cycle", fall, 0);

        // tick held high: 7 cycles from input edge to debounced
        tick = 1'b1;
        bouncy_in = 1'b1;
        repeat (6) step();
        check("held_deb_at6", debounced, 0);
        step();
        check("held_deb_at7", debounced, 1);
        check("held_rise", rise, 1);
        check("held_count2", press_count, 2);
        step();
        check("held_rise_one_cycle", rise, 0);

        // Asynchronous reset mid-run with input high
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_debounced", debounced, 0);
        check("async_rise", rise, 0);
        check("async_fall", fall, 0);
        check("async_count", press_count, 0);
        check("async_state", dut.state_q, S_LOW);
        bouncy_in = 1'b0;
        step();
        rst = 1'b1;
        repeat (3) step();
        check("after_reset_no_fall", fall, 0);

        // 256 presses: wrap to zero
        r0 = rise_cnt;
        for (int i = 0; i < 256; i++) begin
            bouncy_in = 1'b1;
            repeat (9) step();
            bouncy_in = 1'b0;
            repeat (9) step();
            if (i == 254) check("wrap_255", press_count, 255);
        end
        check("wrap_0", press_count, 0);
        check("wrap_rises", rise_cnt - r0, 256);
        check("never_both", both_cnt, 0);
        tick = 1'b0;

        // STABLE_TICKS=1 instance: one qualifying tick is enough
        bouncy1 = 1'b1;
        repeat (3) step();
        check("st1_wait_low", dut1.state_q, S_LOW);
        tick1 = 1'b1;
        step();
        tick1 = 1'b0;
        check("st1_state_high", dut1.state_q, S_HIGH);
        step();
        check("st1_debounced", debounced1, 1);
        check("st1_rise", rise1, 1);
        check("st1_count", press_count1, 1);
        bouncy1 = 1'b0;
        repeat (3) step();
        tick1 = 1'b1;
        step();
        tick1 = 1'b0;
        step();
        check("st1_fall", fall1, 1);
        check("st1_debounced_low", debounced1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tick_debouncer
`default_nettype wire
